dmem_banked_hs: RTL and testbench

//   Next-generation data memory for the RV32 core: byte-addressable, little-endian, and

---
 rtl/mem_pkg.sv | 26 ++
 rtl/dmem_lane_align.sv | 51 +++++
 rtl/dmem_banked_hs.sv | 119 +++++++++++
 tb/tb_dmem_banked_hs.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared definitions for the RV32 data memory: access sizes, FSM states,
// latency counter width and the latched request record.
package mem_pkg;

    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;

    localparam int MAX_LATENCY = 15;
    localparam int CNT_W       = $clog2(MAX_LATENCY + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    typedef struct packed {
        logic [31:0] addr;
        logic        write;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] wdata;
    } mem_req_t;

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational byte-lane steering for little-endian RV32 accesses: store byte
// enables and replicated store data, load extract with sign/zero extension.
module dmem_lane_align
    import mem_pkg::*;
(
    input  logic [1:0]  i_addr_lo,
    input  logic [1:0]  i_size,
    input  logic        i_unsigned,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rword,
    output logic [3:0]  o_be,
    output logic [31:0] o_wword,
    output logic [31:0] o_rdata,
    output logic        o_misalign
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_byte = i_rword[{i_addr_lo, 3'b000} +: 8];
    assign w_half = i_rword[{i_addr_lo[1], 4'b0000} +: 16];

    // Store data is replicated across lanes so the byte enables alone pick the target.
    always_comb begin
        o_be       = 4'b0000;
        o_wword    = i_wdata;
        o_rdata    = 32'h0;
        o_misalign = 1'b0;
        case (i_size)
            SIZE_B: begin
                o_be    = 4'b0001 << i_addr_lo;
                o_wword = {4{i_wdata[7:0]}};
                o_rdata = {{24{w_byte[7] & ~i_unsigned}}, w_byte};
            end
            SIZE_H: begin
                o_misalign = i_addr_lo[0];
                o_be       = i_addr_lo[1] ? 4'b1100 : 4'b0011;
                o_wword    = {2{i_wdata[15:0]}};
                o_rdata    = {{16{w_half[15] & ~i_unsigned}}, w_half};
            end
            SIZE_W: begin
                o_misalign = |i_addr_lo;
                o_be       = 4'b1111;
                o_wword    = i_wdata;
                o_rdata    = i_rword;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/dmem_banked_hs.sv
// RV32 data memory with valid/ready request handshake, configurable access
// latency and registered one-cycle response pulse.
module dmem_banked_hs
    import mem_pkg::*;
#(
    parameter int    MEM_DEPTH      = 16384,
    parameter int    LATENCY        = 1,
    parameter bit    CLEAR_ON_RESET = 1'b1,
    parameter string INIT_FILE      = ""
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_error
);

    localparam int AW = $clog2(MEM_DEPTH);

    state_t            r_state, w_state_nxt;
    logic [CNT_W-1:0]  r_cnt;
    mem_req_t          r_req;
    logic [31:0]       r_mem [MEM_DEPTH];
    logic              r_resp_valid;
    logic [31:0]       r_resp_rdata;
    logic              r_resp_error;

    logic              w_ready, w_accept, w_exec;
    logic [AW-1:0]     w_idx;
    logic [31:0]       w_rword;
    logic [3:0]        w_be;
    logic [31:0]       w_wword, w_ld;
    logic              w_misalign, w_oor, w_err, w_we;

    always_comb begin
        w_state_nxt = r_state;
        w_exec      = 1'b0;
        w_ready     = ((r_state == ST_IDLE) || (r_state == ST_RESP)) && !reset;
        w_accept    = req_valid && w_ready;
        case (r_state)
            ST_IDLE: if (w_accept) w_state_nxt = ST_WAIT;
            ST_WAIT: if (r_cnt == '0) begin
                w_state_nxt = ST_RESP;
                w_exec      = 1'b1;
            end
            ST_RESP: w_state_nxt = w_accept ? ST_WAIT : ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_req        <= '0;
            r_resp_valid <= 1'b0;
            r_resp_rdata <= 32'h0;
            r_resp_error <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_resp_valid <= w_exec;
            if (w_accept) begin
                r_req <= '{addr: req_addr, write: req_write, size: req_size,
                           uns: req_unsigned, wdata: req_wdata};
                r_cnt <= CNT_W'(LATENCY - 1);
            end else if (r_state == ST_WAIT && r_cnt != '0) begin
                r_cnt <= r_cnt - 1'b1;
            end
            if (w_exec) begin
                r_resp_error <= w_err;
                r_resp_rdata <= (w_err || r_req.write) ? 32'h0 : w_ld;
            end
        end
    end

    // Range check uses the full word index so aliasing addresses never reach the array.
    assign w_idx   = r_req.addr[AW+1:2];
    assign w_oor   = {2'b00, r_req.addr[31:2]} >= 32'(MEM_DEPTH);
    assign w_err   = w_misalign || (r_req.size == 2'b11) || w_oor;
    assign w_we    = w_exec && r_req.write && !w_err && !reset;
    assign w_rword = w_oor ? 32'h0 : r_mem[w_idx];

    dmem_lane_align u_align (
        .i_addr_lo  (r_req.addr[1:0]),
        .i_size     (r_req.size),
        .i_unsigned (r_req.uns),
        .i_wdata    (r_req.wdata),
        .i_rword    (w_rword),
        .o_be       (w_be),
        .o_wword    (w_wword),
        .o_rdata    (w_ld),
        .o_misalign (w_misalign)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            if (CLEAR_ON_RESET) begin
                for (int i = 0; i < MEM_DEPTH; i++) r_mem[i] <= 32'h0;
            end
        end else if (w_we) begin
            for (int b = 0; b < 4; b++) begin
                if (w_be[b]) r_mem[w_idx][8*b +: 8] <= w_wword[8*b +: 8];
            end
        end
    end

    assign req_ready  = w_ready;
    assign resp_valid = r_resp_valid;
    assign resp_rdata = r_resp_rdata;
    assign resp_error = r_resp_error;

endmodule

// File: tb/tb_dmem_banked_hs.sv
// Scoreboard bench: one instance at LATENCY=1 (contents kept over reset) and
// one at LATENCY=4 (cleared on reset, small depth for the range check).
module tb_dmem_banked_hs;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst1, d1_valid, d1_ready, d1_write, d1_uns, d1_resp_valid, d1_resp_error;
    logic [1:0]  d1_size;
    logic [31:0] d1_addr, d1_wdata, d1_resp_rdata;
    logic        rst4, d4_valid, d4_ready, d4_write, d4_uns, d4_resp_valid, d4_resp_error;
    logic [1:0]  d4_size;
    logic [31:0] d4_addr, d4_wdata, d4_resp_rdata;

    dmem_banked_hs #(.MEM_DEPTH(16384), .LATENCY(1), .CLEAR_ON_RESET(1'b0)) dut1 (
        .clk(clk), .reset(rst1), .req_valid(d1_valid), .req_ready(d1_ready),
        .req_addr(d1_addr), .req_write(d1_write), .req_size(d1_size),
        .req_unsigned(d1_uns), .req_wdata(d1_wdata), .resp_valid(d1_resp_valid),
        .resp_rdata(d1_resp_rdata), .resp_error(d1_resp_error)
    );

    dmem_banked_hs #(.MEM_DEPTH(1024), .LATENCY(4), .CLEAR_ON_RESET(1'b1)) dut4 (
        .clk(clk), .reset(rst4), .req_valid(d4_valid), .req_ready(d4_ready),
        .req_addr(d4_addr), .req_write(d4_write), .req_size(d4_size),
        .req_unsigned(d4_uns), .req_wdata(d4_wdata), .resp_valid(d4_resp_valid),
        .resp_rdata(d4_resp_rdata), .resp_error(d4_resp_error)
    );

    typedef struct {
        logic [31:0] rd;
        logic        err;
        int          id;
    } exp_t;

    exp_t q1[$];
    exp_t q4[$];
    exp_t e1, e4;
    int   n_chk  = 0;
    int   n_fail = 0;
    int   id_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (d1_resp_valid) begin
            if (q1.size() == 0) chk("d1_spurious_resp", 32'(d1_resp_valid), 32'd0);
            else begin
                e1 = q1.pop_front();
                chk($sformatf("d1_rdata#%0d", e1.id), d1_resp_rdata, e1.rd);
                chk($sformatf("d1_error#%0d", e1.id), 32'(d1_resp_error), 32'(e1.err));
            end
        end
        if (d4_resp_valid) begin
            if (q4.size() == 0) chk("d4_spurious_resp", 32'(d4_resp_valid), 32'd0);
            else begin
                e4 = q4.pop_front();
                chk($sformatf("d4_rdata#%0d", e4.id), d4_resp_rdata, e4.rd);
                chk($sformatf("d4_error#%0d", e4.id), 32'(d4_resp_error), 32'(e4.err));
            end
        end
    end

    task automatic drive(input int sel, input logic v, input logic wr, input logic [1:0] sz,
                         input logic uns, input logic [31:0] a, input logic [31:0] wd);
        if (sel == 1) begin
            d1_valid = v; d1_write = wr; d1_size = sz; d1_uns = uns; d1_addr = a; d1_wdata = wd;
        end else begin
            d4_valid = v; d4_write = wr; d4_size = sz; d4_uns = uns; d4_addr = a; d4_wdata = wd;
        end
    endtask

    function automatic logic rdy(input int sel);
        return (sel == 1) ? d1_ready : d4_ready;
    endfunction

    function automatic logic rvld(input int sel);
        return (sel == 1) ? d1_resp_valid : d4_resp_valid;
    endfunction

    task automatic push_exp(input int sel, input logic [31:0] rd, input logic err);
        exp_t e;
        e.rd = rd; e.err = err; e.id = id_cnt++;
        if (sel == 1) q1.push_back(e); else q4.push_back(e);
    endtask

    // One request: wait for ready, push expectation, then time the response.
    task automatic do_req(input int sel, input logic wr, input logic [1:0] sz, input logic uns,
                          input logic [31:0] a, input logic [31:0] wd,
                          input logic [31:0] erd, input logic eerr);
        int n;
        @(negedge clk);
        drive(sel, 1'b1, wr, sz, uns, a, wd);
        n = 0;
        while (!rdy(sel) && n < 20) begin @(negedge clk); n++; end
        chk($sformatf("d%0d_ready@%h", sel, a), 32'(rdy(sel)), 32'd1);
        push_exp(sel, erd, eerr);
        @(posedge clk);
        #1 drive(sel, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
        n = 0;
        while (n < 20) begin
            @(posedge clk); n++;
            @(negedge clk);
            if (rvld(sel)) break;
        end
        chk($sformatf("d%0d_latency@%h", sel, a), n, (sel == 1) ? 32'd1 : 32'd4);
    endtask

    initial begin
        int n;
        rst1 = 1'b1; rst4 = 1'b1;
        drive(1, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
        drive(4, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
        repeat (3) @(negedge clk);
        d1_valid = 1'b1;
        chk("rst_d1_ready", 32'(d1_ready), 32'd0);
        chk("rst_d1_valid", 32'(d1_resp_valid), 32'd0);
        chk("rst_d1_rdata", d1_resp_rdata, 32'h0);
        chk("rst_d1_error", 32'(d1_resp_error), 32'd0);
        chk("rst_d4_ready", 32'(d4_ready), 32'd0);
        d1_valid = 1'b0;
        rst1 = 1'b0; rst4 = 1'b0;
        @(negedge clk);
        chk("post_rst_d1_ready", 32'(d1_ready), 32'd1);
        chk("post_rst_d4_ready", 32'(d4_ready), 32'd1);

        // word store/load, byte lane merge, sign/zero extension
        do_req(1, 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0,        1'b0);
        do_req(1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0,        32'hDEADBEEF, 1'b0);
        do_req(1, 1'b1, 2'b00, 1'b0, 32'h13, 32'h00000080, 32'h0,        1'b0);
        do_req(1, 1'b0, 2'b00, 1'b0, 32'h13, 32'h0,        32'hFFFFFF80, 1'b0);
        do_req(1, 1'b0, 2'b00, 1'b1, 32'h13, 32'h0,        32'h00000080, 1'b0);
        do_req(1, 1'b0, 2'b10, 1'b1, 32'h10, 32'h0,        32'h80ADBEEF, 1'b0);

        // misaligned half store must not write; misaligned word load errors
        do_req(1, 1'b1, 2'b10, 1'b0, 32'h20, 32'hCAFEF00D, 32'h0,        1'b0);
        do_req(1, 1'b1, 2'b01, 1'b0, 32'h21, 32'h00001234, 32'h0,        1'b1);
        do_req(1, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0,        32'hCAFEF00D, 1'b0);
        do_req(1, 1'b0, 2'b10, 1'b0, 32'h22, 32'h0,        32'h0,        1'b1);

        // reset during WAIT drops the store
        do_req(1, 1'b1, 2'b10, 1'b0, 32'h40, 32'h11223344, 32'h0,        1'b0);
        @(negedge clk);
        drive(1, 1'b1, 1'b1, 2'b10, 1'b0, 32'h40, 32'hA5A5A5A5);
        @(posedge clk);
        #1 drive(1, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);
        rst1 = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("rst_wait_no_resp", 32'(d1_resp_valid), 32'd0);
        end
        rst1 = 1'b0;
        do_req(1, 1'b0, 2'b10, 1'b0, 32'h40, 32'h0,        32'h11223344, 1'b0);

        // LATENCY=4: clear, halfword extension, out-of-range and illegal size
        do_req(4, 1'b0, 2'b10, 1'b0, 32'h8,    32'h0,        32'h0,        1'b0);
        do_req(4, 1'b1, 2'b01, 1'b0, 32'h102,  32'h00008001, 32'h0,        1'b0);
        do_req(4, 1'b0, 2'b01, 1'b0, 32'h102,  32'h0,        32'hFFFF8001, 1'b0);
        do_req(4, 1'b0, 2'b01, 1'b1, 32'h102,  32'h0,        32'h00008001, 1'b0);
        do_req(4, 1'b0, 2'b10, 1'b0, 32'h100,  32'h0,        32'h80010000, 1'b0);
        do_req(4, 1'b1, 2'b10, 1'b0, 32'h1000, 32'h5555AAAA, 32'h0,        1'b1);
        do_req(4, 1'b0, 2'b10, 1'b0, 32'h0,    32'h0,        32'h0,        1'b0);
        do_req(4, 1'b0, 2'b11, 1'b0, 32'h0,    32'h0,        32'h0,        1'b1);
        do_req(4, 1'b1, 2'b10, 1'b0, 32'h104,  32'h0BADF00D, 32'h0,        1'b0);

        // req_valid held high: accepts every 5 cycles, responses coincide with RESP
        @(negedge clk);
        repeat (3) push_exp(4, 32'h0BADF00D, 1'b0);
        drive(4, 1'b1, 1'b0, 2'b10, 1'b0, 32'h104, 32'h0);
        for (int c = 0; c <= 10; c++) begin
            chk($sformatf("tput_ready_c%0d", c), 32'(d4_ready), 32'((c % 5) == 0));
            chk($sformatf("tput_resp_c%0d", c), 32'(d4_resp_valid), 32'((c % 5) == 0 && c > 0));
            if (c < 10) @(negedge clk);
        end
        @(posedge clk);
        #1 drive(4, 1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);

        n = 0;
        while ((q1.size() != 0 || q4.size() != 0) && n < 50) begin @(negedge clk); n++; end
        chk("queues_drained", q1.size() + q4.size(), 32'd0);
        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
